// File: rtl/alarm_set_ctrl.sv
// Alarm mode/sequencing controller: edits the stored alarm time, arms it, rings/snoozes the buzzer.
// Latency: button edits and state changes appear one cycle after the pulse; buzz/state_o/disp_alarm are registered.
// Backpressure: none; buttons are single-cycle pulses, priority btn_mode > btn_snooze > btn_inc. Option: EDIT_TIMEOUT_EN.
module alarm_set_ctrl #(
    parameter int RING_LEN     = 10,
    parameter int SNOOZE_LEN   = 20,
    parameter int MAX_SNOOZE   = 3,
    parameter int EDIT_TIMEOUT = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_snooze,
    input  logic [3:0] cnt3,
    input  logic [3:0] cnt2,
    input  logic [3:0] cnt1,
    input  logic [3:0] cnt0,
    output logic [1:0] al_hr1,
    output logic [3:0] al_hr0,
    output logic [2:0] al_min1,
    output logic [3:0] al_min0,
    output logic       alarm_en,
    output logic       buzz,
    output logic [2:0] state_o,
    output logic       disp_alarm
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EDIT_HR  = 3'd1,
        EDIT_MIN = 3'd2,
        RINGING  = 3'd3,
        SNOOZE   = 3'd4
    } state_t;

    // One down-counter serves both the ring and snooze periods; it only needs to hold LEN-1.
    localparam int TMAX = (RING_LEN > SNOOZE_LEN) ? RING_LEN : SNOOZE_LEN;
    localparam int TW   = (TMAX < 3) ? 1 : $clog2(TMAX);
    localparam int SW   = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);

    localparam logic [TW-1:0] RING_LOAD = TW'(RING_LEN - 1);
    localparam logic [TW-1:0] SNZ_LOAD  = TW'(SNOOZE_LEN - 1);
    localparam logic [SW-1:0] SNZ_MAX   = SW'(MAX_SNOOZE);

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_al_hr1;
    logic [3:0]    r_al_hr0;
    logic [2:0]    r_al_min1;
    logic [3:0]    r_al_min0;
    logic          r_alarm_en;
    logic          r_buzz;
    logic          r_disp;
    logic          r_match_q;
    logic [TW-1:0] r_tmr;
    logic [SW-1:0] r_snooze_used;
    logic          w_match;
    logic          w_trigger;
    logic          w_inc;
    logic          w_edit_expire;

    assign w_match   = ({cnt3, cnt2, cnt1, cnt0} ==
                        {2'b00, r_al_hr1, r_al_hr0, 1'b0, r_al_min1, r_al_min0});
    // Rising edge of match only, so a whole minute of equality rings once.
    assign w_trigger = w_match & ~r_match_q & r_alarm_en & (r_state == IDLE);
    // btn_inc is dropped whenever a higher-priority button fires in the same cycle.
    assign w_inc     = btn_inc & ~btn_mode & ~btn_snooze;

`ifdef EDIT_TIMEOUT_EN
    localparam int ETW = (EDIT_TIMEOUT < 3) ? 1 : $clog2(EDIT_TIMEOUT);
    logic [ETW-1:0] r_edit_cnt;
    logic           w_any_btn;

    assign w_any_btn     = btn_mode | btn_inc | btn_snooze;
    assign w_edit_expire = ~w_any_btn && (r_edit_cnt == ETW'(EDIT_TIMEOUT - 1));

    // Idle-cycle counter for the edit states; any button restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_edit_cnt <= '0;
        end else if ((r_state != EDIT_HR && r_state != EDIT_MIN) || w_any_btn || w_edit_expire) begin
            r_edit_cnt <= '0;
        end else begin
            r_edit_cnt <= r_edit_cnt + ETW'(1);
        end
    end
`else
    assign w_edit_expire = 1'b0;
`endif

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (btn_mode)       w_next = EDIT_HR;
                else if (w_trigger) w_next = RINGING;
            end
            EDIT_HR: begin
                if (btn_mode)           w_next = EDIT_MIN;
                else if (w_edit_expire) w_next = IDLE;
            end
            EDIT_MIN: begin
                if (btn_mode || w_edit_expire) w_next = IDLE;
            end
            RINGING: begin
                if (btn_mode)                                    w_next = IDLE;
                else if (btn_snooze && (r_snooze_used < SNZ_MAX)) w_next = SNOOZE;
                else if (r_tmr == '0)                            w_next = IDLE;
            end
            SNOOZE: begin
                if (btn_mode)         w_next = IDLE;
                else if (r_tmr == '0) w_next = RINGING;
            end
            default: w_next = IDLE;
        endcase
    end

    // State register with registered outputs aligned to the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_buzz    <= 1'b0;
            r_disp    <= 1'b0;
            r_match_q <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_buzz    <= (w_next == RINGING);
            r_disp    <= (w_next == EDIT_HR) || (w_next == EDIT_MIN);
            r_match_q <= w_match;
        end
    end

    // Ring/snooze period timer, reloaded on entry to each phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmr         <= '0;
            r_snooze_used <= '0;
        end else begin
            if (w_next == RINGING && r_state != RINGING)     r_tmr <= RING_LOAD;
            else if (w_next == SNOOZE && r_state != SNOOZE)  r_tmr <= SNZ_LOAD;
            else if (r_tmr != '0)                            r_tmr <= r_tmr - TW'(1);

            if (r_state == IDLE && w_next == RINGING)         r_snooze_used <= '0;
            else if (r_state == RINGING && w_next == SNOOZE)  r_snooze_used <= r_snooze_used + SW'(1);
        end
    end

    // Alarm time and arm flag, edited only by the buttons.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_al_hr1   <= 2'd0;
            r_al_hr0   <= 4'd7;
            r_al_min1  <= 3'd0;
            r_al_min0  <= 4'd0;
            r_alarm_en <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_inc) r_alarm_en <= ~r_alarm_en;
                end
                EDIT_HR: begin
                    if (w_inc) begin
                        if (r_al_hr1 == 2'd2 && r_al_hr0 == 4'd3) begin
                            r_al_hr1 <= 2'd0;
                            r_al_hr0 <= 4'd0;
                        end else if (r_al_hr0 == 4'd9) begin
                            r_al_hr1 <= r_al_hr1 + 2'd1;
                            r_al_hr0 <= 4'd0;
                        end else begin
                            r_al_hr0 <= r_al_hr0 + 4'd1;
                        end
                    end
                end
                EDIT_MIN: begin
                    if (btn_mode) begin
                        r_alarm_en <= 1'b1;
                    end else if (w_inc) begin
                        if (r_al_min0 == 4'd9) begin
                            r_al_min0 <= 4'd0;
                            r_al_min1 <= (r_al_min1 == 3'd5) ? 3'd0 : r_al_min1 + 3'd1;
                        end else begin
                            r_al_min0 <= r_al_min0 + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign al_hr1     = r_al_hr1;
    assign al_hr0     = r_al_hr0;
    assign al_min1    = r_al_min1;
    assign al_min0    = r_al_min0;
    assign alarm_en   = r_alarm_en;
    assign buzz       = r_buzz;
    assign state_o    = r_state;
    assign disp_alarm = r_disp;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Directed bench for alarm_set_ctrl: edit, arm, ring, snooze, dismiss and reset sequences.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
// Expected values are hand-computed from the default parameters (10/20/3/50).
module tb_alarm_set_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_snooze = 1'b0;
    logic [3:0] cnt3 = 4'd0, cnt2 = 4'd7, cnt1 = 4'd0, cnt0 = 4'd0;
    logic [1:0] al_hr1;
    logic [3:0] al_hr0;
    logic [2:0] al_min1;
    logic [3:0] al_min0;
    logic       alarm_en;
    logic       buzz;
    logic [2:0] state_o;
    logic       disp_alarm;

    int n_chk = 0;
    int n_err = 0;

    alarm_set_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .btn_snooze (btn_snooze),
        .cnt3       (cnt3),
        .cnt2       (cnt2),
        .cnt1       (cnt1),
        .cnt0       (cnt0),
        .al_hr1     (al_hr1),
        .al_hr0     (al_hr0),
        .al_min1    (al_min1),
        .al_min0    (al_min0),
        .alarm_en   (alarm_en),
        .buzz       (buzz),
        .state_o    (state_o),
        .disp_alarm (disp_alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic m, input logic s, input logic i);
        btn_mode   = m;
        btn_snooze = s;
        btn_inc    = i;
        step(1);
        btn_mode   = 1'b0;
        btn_snooze = 1'b0;
        btn_inc    = 1'b0;
    endtask

    task automatic set_time(input logic [3:0] h1, input logic [3:0] h0,
                            input logic [3:0] m1, input logic [3:0] m0);
        cnt3 = h1; cnt2 = h0; cnt1 = m1; cnt0 = m0;
    endtask

    // Count further consecutive cycles in state st (bounded).
    task automatic count_state(input logic [2:0] st, inout int n);
        for (int k = 0; k < 40; k++) begin
            step(1);
            if (state_o == st) n++;
            else break;
        end
    endtask

    initial begin
        int n;
        int hi;

        // ---- 1: reset, arm, ring length ----
        #2 rst = 1'b0;
        #1;
        check("rst_state", state_o, 0);
        check("rst_hr0", al_hr0, 7);
        check("rst_hr1", al_hr1, 0);
        check("rst_min", {al_min1, al_min0}, 0);
        check("rst_en", alarm_en, 0);
        check("rst_buzz", buzz, 0);
        check("rst_disp", disp_alarm, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        step(3);
        check("disarmed_no_ring", {state_o, buzz}, 0);
        pulse(0, 0, 1);
        check("arm_toggle", alarm_en, 1);
        check("arm_no_ring", state_o, 0);
        set_time(0, 6, 5, 9);
        step(1);
        set_time(0, 7, 0, 0);
        step(1);
        check("ring_start_state", state_o, 3);
        check("ring_start_buzz", buzz, 1);
        n = 1;
        for (int k = 0; k < 40; k++) begin
            step(1);
            if (buzz) n++;
            else break;
        end
        check("ring_len", n, 10);
        check("ring_end_state", state_o, 0);

        // ---- 2: edit alarm to 00:45 ----
        pulse(0, 0, 1);
        check("disarm", alarm_en, 0);
        pulse(1, 0, 0);
        check("edit_hr_state", state_o, 1);
        check("edit_hr_disp", disp_alarm, 1);
        for (int k = 1; k <= 17; k++) begin
            pulse(0, 0, 1);
            if (k == 3)  check("hr_carry_10", {al_hr1, al_hr0}, {2'd1, 4'd0});
            if (k == 16) check("hr_23", {al_hr1, al_hr0}, {2'd2, 4'd3});
        end
        check("hr_wrap_00", {al_hr1, al_hr0}, 0);
        check("edit_hr_en_kept", alarm_en, 0);
        pulse(1, 0, 0);
        check("edit_min_state", state_o, 2);
        check("edit_min_disp", disp_alarm, 1);
        for (int k = 1; k <= 105; k++) begin
            pulse(0, 0, 1);
            if (k == 10) check("min_10", {al_min1, al_min0}, {3'd1, 4'd0});
            if (k == 59) check("min_59", {al_min1, al_min0}, {3'd5, 4'd9});
            if (k == 60) check("min_wrap_00", {al_min1, al_min0}, 0);
        end
        check("min_45", {al_min1, al_min0}, {3'd4, 4'd5});
        pulse(1, 0, 0);
        check("exit_state", state_o, 0);
        check("exit_disp", disp_alarm, 0);
        check("exit_en_set", alarm_en, 1);
        check("exit_hr_kept", {al_hr1, al_hr0}, 0);

        // ---- 3: snooze three times, fourth ignored ----
        set_time(0, 0, 4, 4);
        step(1);
        set_time(0, 0, 4, 5);
        step(1);
        check("t3_ring", {state_o, buzz}, {3'd3, 1'b1});
        for (int s = 0; s < 3; s++) begin
            pulse(0, 1, 0);
            check("snooze_enter", {state_o, buzz}, {3'd4, 1'b0});
            n = 1;
            count_state(3'd4, n);
            check("snooze_len", n, 20);
            check("snooze_back_ring", {state_o, buzz}, {3'd3, 1'b1});
        end
        pulse(0, 1, 0);
        check("snooze4_ignored", {state_o, buzz}, {3'd3, 1'b1});
        n = 2;
        count_state(3'd3, n);
        check("final_ring_len", n, 10);
        check("t3_end_state", {state_o, buzz}, 0);
        check("t3_en_kept", alarm_en, 1);

        // ---- 4: dismiss beats snooze ----
        set_time(0, 0, 4, 4);
        step(1);
        set_time(0, 0, 4, 5);
        step(1);
        check("t4_ring", state_o, 3);
        pulse(1, 1, 0);
        check("dismiss_state", state_o, 0);
        check("dismiss_buzz", buzz, 0);
        check("dismiss_en_kept", alarm_en, 1);

        // ---- 5: no retrigger while held; async reset mid-ring ----
        hi = 0;
        for (int k = 0; k < 100; k++) begin
            step(1);
            if (buzz || state_o != 3'd0) hi++;
        end
        check("no_retrigger", hi, 0);
        set_time(0, 0, 4, 4);
        step(1);
        set_time(0, 0, 4, 5);
        step(3);
        check("t5_ring_c3", {state_o, buzz}, {3'd3, 1'b1});
        #1 rst = 1'b0;
        #1;
        check("async_rst_buzz", buzz, 0);
        check("async_rst_state", state_o, 0);
        check("async_rst_alarm", {al_hr1, al_hr0, al_min1, al_min0}, {2'd0, 4'd7, 3'd0, 4'd0});
        check("async_rst_en", alarm_en, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        step(1);

`ifdef EDIT_TIMEOUT_EN
        // ---- 6: edit timeout ----
        set_time(1, 2, 3, 4);
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        pulse(0, 0, 1);
        check("to_min_02", {al_min1, al_min0}, 2);
        step(49);
        check("to_not_yet", state_o, 2);
        step(1);
        check("to_idle", state_o, 0);
        check("to_min_kept", {al_min1, al_min0}, 2);
        check("to_hr_kept", {al_hr1, al_hr0}, 7);
        check("to_en_unchanged", alarm_en, 0);
        check("to_disp", disp_alarm, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/alarm_set_ctrl.md
Name: alarm_set_ctrl

Overview:
- Mode/sequencing controller for the alarm clock.
- Owns the stored alarm time and lets the user edit it with the mode and inc buttons.
- Watches the running time from the clock counter (cnt3..cnt0) and drives the buzzer, with ring timeout, snooze and dismiss.
- Sits between the debounced button inputs and the clock counter; drives the LED/buzzer output and the 7-seg display source select.

Parameters:
RING_LEN, 10, clk cycles buzz stays high per ring period (>=2)
SNOOZE_LEN, 20, clk cycles of silence per snooze (>=2)
MAX_SNOOZE, 3, snoozes allowed per alarm event; further btn_snooze ignored
EDIT_TIMEOUT, 50, idle clk cycles before an edit state auto-exits (used only with EDIT_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
btn_mode  in  1  one-cycle pulse, pre-debounced: enter/advance/exit edit; dismiss ring
btn_inc  in  1  one-cycle pulse: increment selected field; in IDLE toggles alarm_en
btn_snooze  in  1  one-cycle pulse: snooze while ringing
cnt3  in  4  current time, hour tens, BCD 0-2
cnt2  in  4  current time, hour units, BCD
cnt1  in  4  current time, minute tens, BCD 0-5
cnt0  in  4  current time, minute units, BCD
al_hr1  out  2  alarm hour tens
al_hr0  out  4  alarm hour units
al_min1  out  3  alarm minute tens
al_min0  out  4  alarm minute units
alarm_en  out  1  alarm armed
buzz  out  1  buzzer/LED drive, registered
state_o  out  3  FSM state: IDLE=0, EDIT_HR=1, EDIT_MIN=2, RINGING=3, SNOOZE=4
disp_alarm  out  1  1 in EDIT_HR/EDIT_MIN: display shows alarm time instead of cnt*

Behaviour:
- Reset (rst=0, async):
  - State IDLE; alarm time 07:00 (al_hr1=0, al_hr0=7, al_min1=0, al_min0=0).
  - alarm_en=0, buzz=0, disp_alarm=0, match_q=0.
  - Ring counter and snooze_used cleared.
  - Asserting reset mid-ring drops buzz immediately.
- match = (cnt3,cnt2,cnt1,cnt0) equals the zero-extended alarm fields.
- match_q = match registered every cycle. Trigger = match & ~match_q & alarm_en & state==IDLE.
  - Exactly one trigger per minute of match.
  - A match edge that occurs outside IDLE is lost and is not re-tried.
- IDLE:
  - btn_mode -> EDIT_HR.
  - else btn_inc -> toggle alarm_en.
  - Trigger -> RINGING; snooze_used=0.
- EDIT_HR:
  - btn_mode -> EDIT_MIN.
  - else btn_inc -> hour+1 in BCD: units 9 -> 0 with tens+1; 23 -> 00.
- EDIT_MIN:
  - btn_mode -> IDLE and alarm_en set to 1.
  - else btn_inc -> minute+1 in BCD: 59 -> 00, no carry into hour.
- Button priority in every state: btn_mode > btn_snooze > btn_inc; lower-priority pulses in the same cycle are dropped.
- RINGING:
  - buzz=1 for exactly RING_LEN cycles, counted from the first cycle in the state; then -> IDLE.
  - btn_mode -> IDLE (dismiss); buzz=0 next cycle.
  - btn_snooze with snooze_used<MAX_SNOOZE -> SNOOZE; snooze_used+1.
  - btn_snooze with snooze_used==MAX_SNOOZE is ignored.
- SNOOZE:
  - buzz=0 for SNOOZE_LEN cycles, then -> RINGING with the ring counter reloaded.
  - btn_mode -> IDLE (cancel).
- buzz = registered (next_state==RINGING), so it is aligned with state_o.
- alarm_en is unchanged by ringing, snoozing or dismissing.
- Edits take effect on the cycle after the btn_inc pulse. match uses the updated value, so a trigger can fire right after the user leaves EDIT_MIN.

Optional Feature:
- Macro EDIT_TIMEOUT_EN.
- Defined:
  - A counter runs in EDIT_HR/EDIT_MIN and clears on any button pulse.
  - Reaching EDIT_TIMEOUT -> IDLE.
  - Edited values are kept; alarm_en is unchanged (not set).
- Undefined: no counter is synthesized; edit states persist indefinitely.

Test Plan:
1. Reset, release; drive time 07:00 with alarm_en=0 -> no buzz. Pulse btn_inc in IDLE -> alarm_en=1. Change time to 06:59 then 07:00 -> buzz=1 for exactly 10 cycles, then state_o=0.
2. btn_mode; 17 x btn_inc; btn_mode; 45 x btn_inc; btn_mode -> alarm 00:45 (07+17 wraps via 23 -> 00), alarm_en=1, disp_alarm high only during edit.
3. Ringing; btn_snooze x4, each pulse in the RINGING phase -> three 20-cycle SNOOZE periods, fourth pulse ignored, ring ends after 10 cycles.
4. Ringing; pulse btn_mode and btn_snooze in the same cycle -> IDLE (dismiss wins), buzz=0 next cycle.
5. Hold time equal to the alarm for 100 cycles after dismiss -> no retrigger. Assert rst in cycle 3 of RINGING -> buzz=0 asynchronously, alarm back to 07:00.
6. With EDIT_TIMEOUT_EN: enter EDIT_MIN, inc twice, wait 50 cycles -> state_o=0, minute +2 retained, alarm_en unchanged.
